// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmit path (and the
// keyboard receive path that sits beside it).
//   - FSM state encoding for ps2_host_tx
//   - error codes reported on tx_err_code
//   - common keyboard command bytes
//   - frame builder (data + odd parity + stop)
package ps2_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_INHIBIT   = 3'd1;
  localparam state_t ST_REQ       = 3'd2;
  localparam state_t ST_WAIT_CLK  = 3'd3;
  localparam state_t ST_SHIFT     = 3'd4;
  localparam state_t ST_ACK       = 3'd5;
  localparam state_t ST_WAIT_IDLE = 3'd6;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_NO_CLK = 2'b01;
  localparam logic [1:0] ERR_FRAME  = 2'b10;
  localparam logic [1:0] ERR_NO_ACK = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  localparam int TIMER_W = 21;

  // Bits in transmit order after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command-byte handshake between a requester and ps2_host_tx.
//   tx_valid/tx_data   request (master -> slave)
//   tx_ready           slave idle, request will be accepted
//   tx_done/tx_err     one-cycle completion pulses
//   tx_err_code        result of the last frame, held until next accept
//   busy               frame in progress (receive path should ignore the bus)
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] tx_err_code;
  logic       busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, tx_err, tx_err_code, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, tx_err, tx_err_code, busy
  );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: synchronizes the raw PS2_CLK / PS2_DATA pins and flags
// device clock falling edges.
//   clk, rst     system clock, async active-high reset
//   pin_clk      raw PS2_CLK pin
//   pin_data     raw PS2_DATA pin
//   sync_clk     synchronized clock line
//   sync_data    synchronized data line (same latency as sync_clk)
//   fall_edge    high for one cycle when sync_clk goes 1 -> 0
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_clk,
  input  logic pin_data,
  output logic sync_clk,
  output logic sync_data,
  output logic fall_edge
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] data_sr;
  logic                   clk_prev;

  // Reset to the idle (released, pulled-up) level so leaving reset cannot
  // fabricate a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sr   <= '1;
      data_sr  <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sr   <= {clk_sr[SYNC_STAGES-2:0], pin_clk};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], pin_data};
      clk_prev <= clk_sr[SYNC_STAGES-1];
    end
  end

  assign sync_clk  = clk_sr[SYNC_STAGES-1];
  assign sync_data = data_sr[SYNC_STAGES-1];
  assign fall_edge = clk_prev & ~sync_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte to
// the keyboard over the open-collector PS2_CLK/PS2_DATA lines.
//   clk, rst      system clock, async active-high reset
//   bus           ps2_host_tx_if.slave command handshake and status
//   ps2_clk_in    raw PS2_CLK pin value
//   ps2_data_in   raw PS2_DATA pin value
//   ps2_clk_oe    1 = pull PS2_CLK low
//   ps2_data_oe   1 = pull PS2_DATA low
// All outputs come straight from flops.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int RQ_TIMEOUT     = 1_500_000,
  parameter int FRAME_TIMEOUT  = 200_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam logic [TIMER_W-1:0] INH_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RQ_LAST  = TIMER_W'(RQ_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] FR_LAST  = TIMER_W'(FRAME_TIMEOUT - 1);

  logic sync_clk, sync_data, fall_edge;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .pin_clk   (ps2_clk_in),
    .pin_data  (ps2_data_in),
    .sync_clk  (sync_clk),
    .sync_data (sync_data),
    .fall_edge (fall_edge)
  );

  state_t               state;
  logic [9:0]           frame;
  logic [3:0]           bit_cnt;
  logic [TIMER_W-1:0]   timer;
  logic                 clk_oe, data_oe;
  logic                 ready, busy_r, done, err;
  logic [1:0]           code;

  logic                 abort;
  logic [1:0]           abort_code;

  // Failure detection. A device edge in the same cycle as a timer expiry
  // wins, since the device did respond in time.
  always_comb begin
    abort      = 1'b0;
    abort_code = ERR_NONE;
    case (state)
      ST_WAIT_CLK:
        if (!fall_edge && timer == RQ_LAST) begin
          abort      = 1'b1;
          abort_code = ERR_NO_CLK;
        end
      ST_SHIFT:
        if (!fall_edge && timer == FR_LAST) begin
          abort      = 1'b1;
          abort_code = ERR_FRAME;
        end
      ST_ACK:
        if (fall_edge && sync_data) begin
          abort      = 1'b1;
          abort_code = ERR_NO_ACK;
        end else if (!fall_edge && timer == FR_LAST) begin
          abort      = 1'b1;
          abort_code = ERR_FRAME;
        end
      ST_WAIT_IDLE:
        if (!(sync_clk && sync_data) && timer == FR_LAST) begin
          abort      = 1'b1;
          abort_code = ERR_FRAME;
        end
      default: ;
    endcase
  end

  // The timer is cleared on entry to INHIBIT, WAIT_CLK and SHIFT. It is
  // deliberately left running across SHIFT -> ACK -> WAIT_IDLE so that
  // FRAME_TIMEOUT bounds the whole frame, not each phase separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      frame   <= '0;
      bit_cnt <= '0;
      timer   <= '0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      ready   <= 1'b1;
      busy_r  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      code    <= ERR_NONE;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      timer <= timer + 1'b1;
      if (abort) begin
        clk_oe  <= 1'b0;
        data_oe <= 1'b0;
        err     <= 1'b1;
        code    <= abort_code;
        state   <= ST_IDLE;
        ready   <= 1'b1;
        busy_r  <= 1'b0;
        bit_cnt <= '0;
        timer   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            timer <= '0;
            if (bus.tx_valid && ready) begin
              frame  <= build_frame(bus.tx_data);
              code   <= ERR_NONE;
              clk_oe <= 1'b1;
              ready  <= 1'b0;
              busy_r <= 1'b1;
              state  <= ST_INHIBIT;
            end
          end
          ST_INHIBIT:
            if (timer == INH_LAST) begin
              data_oe <= 1'b1;
              timer   <= '0;
              state   <= ST_REQ;
            end
          // Start bit is already on the data line; releasing the clock
          // hands control of timing to the device.
          ST_REQ: begin
            clk_oe <= 1'b0;
            timer  <= '0;
            state  <= ST_WAIT_CLK;
          end
          ST_WAIT_CLK:
            if (fall_edge) begin
              data_oe <= ~frame[0];
              bit_cnt <= 4'd1;
              timer   <= '0;
              state   <= ST_SHIFT;
            end
          // bit_cnt 9 is the stop bit (frame[9] = 1), which releases data.
          ST_SHIFT:
            if (fall_edge) begin
              data_oe <= ~frame[bit_cnt];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) state <= ST_ACK;
            end
          ST_ACK:
            if (fall_edge) state <= ST_WAIT_IDLE;
          ST_WAIT_IDLE:
            if (sync_clk && sync_data) begin
              done    <= 1'b1;
              ready   <= 1'b1;
              busy_r  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_IDLE;
            end
          default: begin
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            ready   <= 1'b1;
            busy_r  <= 1'b0;
            state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ps2_clk_oe      = clk_oe;
  assign ps2_data_oe     = data_oe;
  assign bus.tx_ready    = ready;
  assign bus.busy        = busy_r;
  assign bus.tx_done     = done;
  assign bus.tx_err      = err;
  assign bus.tx_err_code = code;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int RQT  = 500;
  localparam int FRT  = 5000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if tx_if();

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe, ps2_data_oe;
  logic clk_line, data_line;

  // Open-collector bus: either side may pull a line low.
  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RQ_TIMEOUT    (RQT),
    .FRAME_TIMEOUT (FRT),
    .SYNC_STAGES   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (tx_if),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: bits a device reads on its rising edges 1..10.
  function automatic logic [9:0] model_bits(input logic [7:0] d);
    int ones = 0;
    logic [9:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i] = d[i];
      if (d[i]) ones++;
    end
    b[8] = ((ones % 2) == 0);
    b[9] = 1'b1;
    return b;
  endfunction

  // Results of the last frame
  logic [9:0] r_bits;
  int r_done, r_err, r_overlap, r_inh, r_req, r_rel_n, r_err_n;
  logic r_rel, r_timeout;
  logic [1:0] r_code_start;

  // Device model. mode: 0 normal ACK, 1 no ACK, 2 never clocks, 3 stops after bit 4.
  task automatic bfm(input int mode);
    int t = 0;
    r_bits = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400 || mode == 2) return;
    repeat (30) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (mode == 3 && k == 6) return;
      if (k == 11 && mode != 1) dev_data = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) r_bits[k-1] = data_line;
    end
    repeat (HALF) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic monitor(input int pulse_at);
    int n = 0;
    bit fin = 0;
    r_done = 0; r_err = 0; r_overlap = 0; r_inh = 0; r_req = 0;
    r_rel_n = -1; r_err_n = -1; r_rel = 1'b1;
    while (!fin && n < 20000) begin
      if (tx_if.tx_ready == tx_if.busy) r_overlap++;
      if (ps2_clk_oe && !ps2_data_oe) r_inh++;
      if (ps2_clk_oe && ps2_data_oe) r_req++;
      if (r_rel_n < 0 && !ps2_clk_oe && ps2_data_oe) r_rel_n = n;
      if (tx_if.tx_done) begin r_done++; fin = 1; end
      if (tx_if.tx_err) begin
        r_err++;
        r_err_n = n;
        r_rel = !ps2_clk_oe && !ps2_data_oe;
        fin = 1;
      end
      if (pulse_at > 0 && n == pulse_at) begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h99;
      end
      if (pulse_at > 0 && n == pulse_at + 1) tx_if.tx_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    r_timeout = !fin;
  endtask

  task automatic run_frame(input logic [7:0] d, input int mode, input int pulse_at);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    r_code_start = tx_if.tx_err_code;
    fork
      bfm(mode);
      monitor(pulse_at);
    join
  endtask

  typedef struct {
    logic [7:0] data;
    int         mode;
    int         exp_done;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[7];

  task automatic check_frame(input string tag, input vec_t v);
    check({tag, "_timeout"}, r_timeout, 1'b0);
    check({tag, "_done"}, r_done, v.exp_done);
    check({tag, "_err"}, r_err, 1 - v.exp_done);
    check({tag, "_code_cleared"}, r_code_start, ERR_NONE);
    check({tag, "_code"}, tx_if.tx_err_code, v.exp_code);
    check({tag, "_idle_after"}, {tx_if.tx_ready, tx_if.busy, tx_if.tx_done, tx_if.tx_err}, 4'b1000);
    check({tag, "_ready_busy"}, r_overlap, 0);
    check({tag, "_inhibit_len"}, r_inh, INH);
    check({tag, "_req_len"}, r_req, 1);
    if (v.mode <= 1) check({tag, "_bits"}, r_bits, model_bits(v.data));
    if (v.exp_done == 0) check({tag, "_release"}, r_rel, 1'b1);
    if (v.mode == 2) check({tag, "_rq_latency"}, r_err_n - r_rel_n, RQT);
  endtask

  initial begin
    int t;
    int viol;
    vec_t rv;

    vecs[0] = '{8'hED, 0, 1, ERR_NONE};
    vecs[1] = '{8'h01, 0, 1, ERR_NONE};
    vecs[2] = '{8'h00, 0, 1, ERR_NONE};
    vecs[3] = '{8'hFF, 0, 1, ERR_NONE};
    vecs[4] = '{8'hA5, 1, 0, ERR_NO_ACK};
    vecs[5] = '{8'h3C, 2, 0, ERR_NO_CLK};
    vecs[6] = '{8'h5A, 3, 0, ERR_FRAME};

    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {tx_if.tx_ready, tx_if.busy, tx_if.tx_done, tx_if.tx_err, tx_if.tx_err_code, ps2_clk_oe, ps2_data_oe},
          8'b1000_0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    check("model_parity_ED", model_bits(CMD_SET_LED), 10'b11_1110_1101);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].data, vecs[i].mode, 0);
      check_frame($sformatf("vec%0d", i), vecs[i]);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_code_held", i), tx_if.tx_err_code, vecs[i].exp_code);
    end

    for (int i = 0; i < 6; i++) begin
      rv = '{8'($urandom_range(0, 255)), 0, 1, ERR_NONE};
      run_frame(rv.data, 0, 0);
      check_frame($sformatf("rand%0d_%02h", i, rv.data), rv);
    end

    // Reset while bit 4 of 0x00 is on the line (data pulled low).
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    t = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("rst_reach_wait_clk", t < 400, 1'b1);
    repeat (30) @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    check("rst_bit4_driven", {ps2_clk_oe, ps2_data_oe, tx_if.busy}, 3'b011);
    #1 rst = 1'b1;
    #1 check("rst_async_release", {ps2_clk_oe, ps2_data_oe, tx_if.tx_ready, tx_if.busy}, 4'b0010);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // tx_valid during busy must neither start a second frame nor alter this one.
    rv = '{8'h12, 0, 1, ERR_NONE};
    run_frame(rv.data, 0, 100);
    check_frame("busy_pulse", rv);
    viol = 0;
    for (int i = 0; i < 60; i++) begin
      if (ps2_clk_oe || ps2_data_oe || !tx_if.tx_ready) viol++;
      @(negedge clk);
    end
    check("busy_pulse_no_second_frame", viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
